comparator_4bit_arbiter: RTL and testbench
==========================================

# comparator_4bit_arbiter

Round-robin arbiter and sequencer that shares one `comparator_4bit` instance among four requesters. Each requester presents a 4-bit operand pair with a request. The block grants one requester at a time, latches that requester's operands into the shared comparator, and returns a registered gt/eq/lt result tagged with the requester ID. It sits between the client blocks and the comparator datapath; the comparator is instantiated internally.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters. Only 4 is verified; the ID width is fixed at 2 bits.
- `WIDTH`, 4: operand width. Must match `comparator_4bit`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester request level; bit i belongs to requester i.
- `a_in`  in  16  packed operand A; requester i uses bits [4i+3:4i].
- `b_in`  in  16  packed operand B; same packing as `a_in`.
- `grant`  out  4  one-hot, one-cycle pulse; operands of requester i were captured.
- `done`  out  4  one-hot, one-cycle pulse; result for requester i is valid.
- `gt`  out  1  registered result, a > b (unsigned).
- `eq`  out  1  registered result, a == b.
- `lt`  out  1  registered result, a < b (unsigned).
- `res_id`  out  2  requester index of the current result.
- `busy`  out  1  high while a comparison is in flight (state CMP).

## Operation
- FSM has two states: IDLE and CMP.
- **IDLE:**
  - If `req` is nonzero at a rising edge, select the winner i by round-robin.
  - Go to CMP, latch `a_in`/`b_in` slice i into internal operand registers, latch i into the ID register, and assert `grant[i]`.
  - If `req` is zero, stay in IDLE.
- **CMP:**
  - The internal comparator evaluates the latched operands combinationally.
  - At the next edge: register `gt`/`eq`/`lt`, set `res_id` = latched ID, pulse `done[i]`, set last-granted pointer = i, and return to IDLE.
  - `req` is ignored in CMP.
- **Round-robin:**
  - Search starts at (last + 1) mod 4 and wraps. The first asserted bit wins.
  - The pointer updates only on completion, not on grant.
- **Requester handshake:**
  - Hold `req` high with stable operands until `grant[i]` is seen.
  - Deassert `req` in the cycle after `grant[i]`.
  - If `req` is still high when the FSM next samples in IDLE, it is a new request and is granted again per round-robin.
  - Operands are sampled only at the grant edge; later changes have no effect on that operation.
- **Results:**
  - `gt`, `eq`, `lt` are unsigned comparisons, exactly one-hot after the first `done`.
  - `gt`/`eq`/`lt`/`res_id` hold their value until the next `done`.
- **Invariants:**
  - `grant` and `done` are never both nonzero in the same cycle.
  - Each is at most one-hot.
- **Reset:**
  - State = IDLE, `grant` = 0, `done` = 0, `gt` = `eq` = `lt` = 0, `res_id` = 0, `busy` = 0, operand registers = 0, last pointer = 3 (so requester 0 has first priority).
  - Reset asserted during CMP aborts the operation: no `done` is issued, and the result registers take reset values.

## Timing
- Edge k (IDLE, `req` nonzero) → in cycle k: `grant[i]` = 1, `busy` = 1.
- Edge k+1 → in cycle k+1: `grant` = 0, `done[i]` = 1, results valid, `busy` = 0.
- Edge k+2 → earliest next grant.
- Grant-to-result latency is 1 cycle; request-to-result latency is 2 edges.
- Peak throughput is one comparison per 2 cycles.
- Outputs are fully registered; there is no combinational path from `req`/`a_in`/`b_in` to any output.
- Reset takes effect immediately on `rst_n` falling. Outputs are valid at reset values without a clock.
- The first grant is possible at the first rising edge after `rst_n` rises.

## Test plan
- **Single request:** `req`=0001, a0=1010, b0=0101 → `grant`=0001 one cycle, then `done`=0001, gt/eq/lt=1/0/0, `res_id`=0.
- **Equal and extreme operands:**
  - Requester 2 with a=1001, b=1001 → eq=1, `res_id`=2.
  - Requester 3 with a=0000, b=1111 → lt=1.
  - Requester 1 with a=1111, b=0000 → gt=1.
- **All four request at once after reset, each dropping `req` after its grant:**
  - Grants 0, 1, 2, 3 at 2-cycle spacing.
  - `done` pulses follow each grant by 1 cycle.
  - `res_id` sequence is 0, 1, 2, 3.
- **Fairness:** `req[0]` and `req[2]` held high continuously → grants alternate 0, 2, 0, 2; no requester is granted twice in a row while the other waits.
- **Operand change after grant:** requester 1 changes a from 0011 to 1111 in the cycle after its grant (b=1010) → result still lt=1.
- **Reset mid-operation:** assert `rst_n`=0 during CMP → `done` never pulses; all outputs return to 0 immediately. After release, requester 0 has priority over a simultaneous requester 3.

Source files
------------

// File: rtl/comparator_4bit_arbiter.sv
// Round-robin arbiter that time-shares one comparator_4bit among four requesters.
// Each comparison takes a grant cycle plus a compare cycle; results are registered and tagged with the requester ID.

module comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

module comparator_4bit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   gt,
  output logic                   eq,
  output logic                   lt,
  output logic [1:0]             res_id,
  output logic                   busy
);

  typedef enum logic {IDLE, CMP} state_t;

  state_t            state, state_next;
  logic [1:0]        last_ptr, last_next;
  logic [1:0]        cur_id, id_next;
  logic [1:0]        pick, cand;
  logic              found;
  logic [WIDTH-1:0]  op_a, op_b, op_a_next, op_b_next;
  logic [N_REQ-1:0]  grant_next, done_next;
  logic              gt_next, eq_next, lt_next, busy_next;
  logic [1:0]        res_id_next;
  logic              cmp_gt, cmp_eq, cmp_lt;

  comparator_4bit #(.WIDTH(WIDTH)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  // Search begins one past the last completed requester; the 2-bit index wraps naturally.
  always_comb begin
    pick  = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next  = state;
    last_next   = last_ptr;
    id_next     = cur_id;
    op_a_next   = op_a;
    op_b_next   = op_b;
    grant_next  = '0;
    done_next   = '0;
    busy_next   = 1'b0;
    gt_next     = gt;
    eq_next     = eq;
    lt_next     = lt;
    res_id_next = res_id;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next       = CMP;
          grant_next[pick] = 1'b1;
          busy_next        = 1'b1;
          id_next          = pick;
          op_a_next        = a_in[int'(pick)*WIDTH +: WIDTH];
          op_b_next        = b_in[int'(pick)*WIDTH +: WIDTH];
        end
      end
      CMP: begin
        // Pointer moves on completion so an aborted operation leaves priority unchanged.
        state_next        = IDLE;
        gt_next           = cmp_gt;
        eq_next           = cmp_eq;
        lt_next           = cmp_lt;
        res_id_next       = cur_id;
        done_next[cur_id] = 1'b1;
        last_next         = cur_id;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_ptr <= 2'd3;
      cur_id   <= 2'd0;
      op_a     <= '0;
      op_b     <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      res_id   <= 2'd0;
    end else begin
      state    <= state_next;
      last_ptr <= last_next;
      cur_id   <= id_next;
      op_a     <= op_a_next;
      op_b     <= op_b_next;
      grant    <= grant_next;
      done     <= done_next;
      busy     <= busy_next;
      gt       <= gt_next;
      eq       <= eq_next;
      lt       <= lt_next;
      res_id   <= res_id_next;
    end
  end

endmodule

// File: tb/tb_comparator_4bit_arbiter.sv
// Scoreboard bench for comparator_4bit_arbiter: stimulus pushes expected grants/results,
// an independent monitor pops and compares whenever grant or done pulses.

module tb_comparator_4bit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        gt, eq, lt;
  logic [1:0]  res_id;
  logic        busy;

  typedef struct {
    int id;
    int gt;
    int eq;
    int lt;
  } res_t;

  int   exp_grant_q[$];
  res_t exp_res_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   last_grant_cycle = -10;

  comparator_4bit_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .grant  (grant),
    .done   (done),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt),
    .res_id (res_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic res_t mkRes(input int id, input int g, input int e, input int l);
    res_t r;
    r.id = id; r.gt = g; r.eq = e; r.lt = l;
    return r;
  endfunction

  // Queue one expected grant and its matching result.
  task automatic expectOp(input int id, input int g, input int e, input int l);
    exp_grant_q.push_back(id);
    exp_res_q.push_back(mkRes(id, g, e, l));
  endtask

  // Raise the requests in mask and drop each bit in the cycle its grant appears.
  task automatic applyStimulus(input logic [3:0] mask);
    logic [3:0] pending;
    int budget;
    pending = mask;
    req = pending;
    budget = 40;
    while (pending != 4'b0000 && budget > 0) begin
      @(negedge clk);
      #1;
      pending = pending & ~grant;
      req = pending;
      budget--;
    end
    if (pending != 4'b0000) begin
      checkOutput("req_timeout", int'(pending), 0);
      req = 4'b0000;
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    exp_grant_q.delete();
    exp_res_q.delete();
    #1;
    checkOutput("rst_grant", int'(grant), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_gt", int'(gt), 0);
    checkOutput("rst_eq", int'(eq), 0);
    checkOutput("rst_lt", int'(lt), 0);
    checkOutput("rst_res_id", int'(res_id), 0);
    checkOutput("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_done_held", int'(done), 0);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares grant/done pulses against the scoreboard queues.
  initial begin
    int   e;
    res_t r;
    forever begin
      @(negedge clk);
      cycle++;
      checkOutput("grant_done_overlap", int'((grant != 4'b0) && (done != 4'b0)), 0);
      if (grant != 4'b0) begin
        if (exp_grant_q.size() == 0) begin
          checkOutput("unexpected_grant", int'(grant), 0);
        end else begin
          e = exp_grant_q.pop_front();
          checkOutput("grant", int'(grant), 1 << e);
          checkOutput("busy_at_grant", int'(busy), 1);
          last_grant_cycle = cycle;
        end
      end
      if (done != 4'b0) begin
        if (exp_res_q.size() == 0) begin
          checkOutput("unexpected_done", int'(done), 0);
        end else begin
          r = exp_res_q.pop_front();
          checkOutput("done", int'(done), 1 << r.id);
          checkOutput("res_id", int'(res_id), r.id);
          checkOutput("gt", int'(gt), r.gt);
          checkOutput("eq", int'(eq), r.eq);
          checkOutput("lt", int'(lt), r.lt);
          checkOutput("busy_at_done", int'(busy), 0);
          checkOutput("grant_to_done_latency", cycle - last_grant_cycle, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int grants_seen;
    int budget;
    req   = 4'b0000;
    a_in  = 16'h0000;
    b_in  = 16'h0000;
    rst_n = 1'b0;
    #2;
    applyReset();

    // Single request: requester 0, 1010 vs 0101.
    @(negedge clk); #1;
    a_in = 16'h000A; b_in = 16'h0005;
    expectOp(0, 1, 0, 0);
    applyStimulus(4'b0001);
    repeat (4) @(negedge clk);
    checkOutput("hold_gt", int'(gt), 1);
    checkOutput("hold_eq", int'(eq), 0);
    checkOutput("hold_lt", int'(lt), 0);
    checkOutput("hold_res_id", int'(res_id), 0);
    checkOutput("idle_busy", int'(busy), 0);
    #1;

    // Equal and extreme operands.
    a_in = 16'h0900; b_in = 16'h0900;
    expectOp(2, 0, 1, 0);
    applyStimulus(4'b0100);
    repeat (2) @(negedge clk); #1;
    a_in = 16'h0000; b_in = 16'hF000;
    expectOp(3, 0, 0, 1);
    applyStimulus(4'b1000);
    repeat (2) @(negedge clk); #1;
    a_in = 16'h00F0; b_in = 16'h0000;
    expectOp(1, 1, 0, 0);
    applyStimulus(4'b0010);
    repeat (2) @(negedge clk);

    // All four at once right after reset.
    applyReset();
    @(negedge clk); #1;
    a_in = 16'hF871; b_in = 16'hE772;
    expectOp(0, 0, 0, 1);
    expectOp(1, 0, 1, 0);
    expectOp(2, 1, 0, 0);
    expectOp(3, 1, 0, 0);
    applyStimulus(4'b1111);
    repeat (3) @(negedge clk); #1;

    // Fairness: requesters 0 and 2 held continuously.
    a_in = 16'h0C03; b_in = 16'h0403;
    expectOp(0, 0, 1, 0);
    expectOp(2, 1, 0, 0);
    expectOp(0, 0, 1, 0);
    expectOp(2, 1, 0, 0);
    req = 4'b0101;
    grants_seen = 0;
    budget = 40;
    while (grants_seen < 4 && budget > 0) begin
      @(negedge clk); #1;
      if (grant != 4'b0) grants_seen++;
      budget--;
    end
    req = 4'b0000;
    checkOutput("fairness_grant_count", grants_seen, 4);
    repeat (3) @(negedge clk); #1;

    // Operand change after grant must not affect the result.
    a_in = 16'h0030; b_in = 16'h00A0;
    expectOp(1, 0, 0, 1);
    applyStimulus(4'b0010);
    a_in = 16'h00F0;
    repeat (3) @(negedge clk); #1;

    // Reset mid-operation, then priority restarts at requester 0.
    a_in = 16'h000A; b_in = 16'h0003;
    expectOp(0, 1, 0, 0);
    applyStimulus(4'b0001);
    applyReset();
    @(negedge clk); #1;
    a_in = 16'hA005; b_in = 16'hA006;
    expectOp(0, 0, 0, 1);
    expectOp(3, 0, 1, 0);
    applyStimulus(4'b1001);
    repeat (4) @(negedge clk);

    checkOutput("pending_grants", exp_grant_q.size(), 0);
    checkOutput("pending_results", exp_res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
